esn_sched: RTL
==============

ESN_SCHED -- requirements
Module: esn_sched

Interface
REQ-001 SHALL have parameter N_NEUR, 8, number of reservoir neurons and readout weights.
REQ-002 SHALL have parameter DW, 32, data and weight width in bits.
REQ-003 SHALL have parameter WASHOUT, 16, number of initial samples whose estimates are suppressed (used only under ESN_WASHOUT_EN).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports in_valid/in_ready/in_data  in/out/in  1/1/DW  input sample handshake.
REQ-007 SHALL have ports res_go/res_idx/res_done  out/out/in  1/log2(N_NEUR)/1  reservoir neuron-update command, index and completion.
REQ-008 SHALL have ports ro_clr/ro_ce/ro_idx  out/out/out  1/1/log2(N_NEUR)  readout accumulator clear, chip enable and index.
REQ-009 SHALL have port acc_in  input  DW  readout accumulator result.
REQ-010 SHALL have ports est_valid/est_ready/est  out/in/out  1/1/DW  estimate output handshake.
REQ-011 SHALL have ports w_wr_valid/w_wr_ready/w_wr_idx/w_wr_data  in/out/in/in  1/1/log2(N_NEUR)/DW  readout-weight write port.
REQ-012 SHALL have port W_out  output  N_NEUR*DW  weight bank; weight i occupies bits [i*DW +: DW].
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, RES, RO, OUT.
REQ-015 SHALL assert in_ready only in IDLE; an accepted sample (in_valid&&in_ready) latches in_data and moves to RES.
REQ-016 SHALL, in RES, pulse res_go for one cycle with res_idx=k, wait for res_done, then issue k+1; after res_done for k=N_NEUR-1 move to RO.
REQ-017 SHALL ignore res_done when no command is outstanding; res_done in the same cycle as res_go is not valid.
REQ-018 SHALL pulse ro_clr in the first RO cycle, then assert ro_ce for exactly N_NEUR consecutive cycles with ro_idx 0..N_NEUR-1.
REQ-019 SHALL latch est from acc_in in the cycle after the last ro_ce, assert est_valid, and move to OUT.
REQ-020 SHALL hold est and est_valid stable in OUT until est_ready; on the handshake return to IDLE (in_ready high next cycle).
REQ-021 SHALL drive w_wr_ready=1 in all states except RO; accepted write updates W_out slot w_wr_idx at the next edge.
REQ-022 SHALL make a write accepted in the last RES cycle visible on W_out before the first ro_ce.
REQ-023 SHALL stall (not drop) writes during RO; w_wr_valid held through RO is accepted in the first non-RO cycle.
REQ-024 SHALL wrap sample counting and indices modulo their widths without error.

Reset
REQ-025 SHALL on rst: state IDLE, W_out=0, est=0, est_valid=0, res_go=0, ro_ce=0, ro_clr=0, indices=0, busy=0, washout counter=0.
REQ-026 SHALL abandon any in-flight sample on rst asserted mid-RES/RO/OUT; no est_valid afterwards for that sample.

Configuration
REQ-027 SHALL support macro ESN_WASHOUT_EN: when defined, the first WASHOUT completed samples after reset skip OUT (return directly to IDLE, est_valid never asserted); counter saturates at WASHOUT.
REQ-028 SHALL, without ESN_WASHOUT_EN, emit an estimate for every sample and contain no washout counter.

Structure
REQ-029 SHALL place N_NEUR, DW, WASHOUT defaults and the FSM state enum in shared package esn_pkg.
REQ-030 SHALL implement the weight bank in sub-module esn_wout_bank (write port in, flat W_out out).

Verification
REQ-031 Write weights 1..8 to idx 0..7, one sample, res_done 2 cycles after each res_go -> 8 res_go pulses, ro_clr then 8 ro_ce cycles, est=acc_in (e.g. 0x00000024), est_valid held until est_ready.
REQ-032 w_wr_valid idx 3 data 0xDEADBEEF asserted during RO -> w_wr_ready low through RO, W_out[3] updated one cycle after leaving RO.
REQ-033 est_ready held low 10 cycles in OUT -> est stable, in_ready low, then IDLE next cycle after est_ready.
REQ-034 rst pulsed during RES at k=4 -> next cycle IDLE, W_out=0, no est_valid.
REQ-035 ESN_WASHOUT_EN, WASHOUT=16, 17 samples -> est_valid only for sample 17; without macro -> 17 estimates.

Source files
------------

// File: rtl/esn_pkg.sv
// -----------------------------------------------------------------------------
// esn_pkg -- shared definitions for the echo-state-network sample scheduler.
//   N_NEUR_DEF  : default number of reservoir neurons / readout weights
//   DW_DEF      : default data and weight width in bits
//   WASHOUT_DEF : default number of leading samples whose estimates are
//                 suppressed when ESN_WASHOUT_EN is defined
//   esn_state_e : scheduler FSM state encoding
// -----------------------------------------------------------------------------
package esn_pkg;

  localparam int unsigned N_NEUR_DEF  = 8;
  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned WASHOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for an input sample
    RES  = 2'd1,  // sequencing reservoir neuron updates
    RO   = 2'd2,  // sequencing the readout accumulator
    OUT  = 2'd3   // presenting the estimate
  } esn_state_e;

endpackage : esn_pkg

// File: rtl/esn_wout_bank.sv
// -----------------------------------------------------------------------------
// esn_wout_bank -- readout weight register bank.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, clears every weight
//   wr_en_i   : write strobe (already qualified by the caller's handshake)
//   wr_idx_i  : weight slot to write
//   wr_data_i : new weight value
//   w_out_o   : all weights, slot i at bits [i*DW +: DW]
// -----------------------------------------------------------------------------
module esn_wout_bank
  import esn_pkg::*;
#(
  parameter int unsigned N_NEUR = N_NEUR_DEF,
  parameter int unsigned DW     = DW_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en_i,
  input  logic [$clog2(N_NEUR)-1:0]   wr_idx_i,
  input  logic [DW-1:0]               wr_data_i,
  output logic [N_NEUR*DW-1:0]        w_out_o
);

  logic [DW-1:0] w_q [N_NEUR];

  // NOTE: the bank is a handful of registers that must read as zero after
  // reset, so every entry is cleared; a real RAM would not be reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_NEUR); i++) begin
        w_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      w_q[wr_idx_i] <= wr_data_i;
    end
  end

  for (genvar g = 0; g < int'(N_NEUR); g++) begin : g_flat
    assign w_out_o[g*DW +: DW] = w_q[g];
  end

endmodule : esn_wout_bank

// File: rtl/esn_sched.sv
// -----------------------------------------------------------------------------
// esn_sched -- per-sample scheduler for an echo-state-network estimator.
// Accepts one input sample, steps the reservoir through N_NEUR neuron updates,
// then drives the readout accumulator over all weights and presents the
// accumulated value as the estimate.
//
// Optional feature macro: ESN_WASHOUT_EN -- when defined, the first WASHOUT
// completed samples after reset produce no estimate.
//
// Ports
//   clk, rst                        : clock; synchronous active-high reset
//   in_valid / in_ready / in_data   : input sample handshake
//   res_go / res_idx / res_done     : reservoir update command and completion
//   ro_clr / ro_ce / ro_idx         : readout accumulator control
//   acc_in                          : readout accumulator result
//   est_valid / est_ready / est     : estimate handshake
//   w_wr_valid / w_wr_ready /
//   w_wr_idx / w_wr_data            : readout weight write port
//   W_out                           : weight bank, slot i at [i*DW +: DW]
//   busy                            : high whenever not IDLE
// -----------------------------------------------------------------------------
module esn_sched
  import esn_pkg::*;
#(
  parameter int unsigned N_NEUR  = N_NEUR_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned WASHOUT = WASHOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DW-1:0]               in_data,
  output logic                        res_go,
  output logic [$clog2(N_NEUR)-1:0]   res_idx,
  input  logic                        res_done,
  output logic                        ro_clr,
  output logic                        ro_ce,
  output logic [$clog2(N_NEUR)-1:0]   ro_idx,
  input  logic [DW-1:0]               acc_in,
  output logic                        est_valid,
  input  logic                        est_ready,
  output logic [DW-1:0]               est,
  input  logic                        w_wr_valid,
  output logic                        w_wr_ready,
  input  logic [$clog2(N_NEUR)-1:0]   w_wr_idx,
  input  logic [DW-1:0]               w_wr_data,
  output logic [N_NEUR*DW-1:0]        W_out,
  output logic                        busy
);

  localparam int unsigned IW = $clog2(N_NEUR);
  // Readout phase counter: 0 = clear, 1..N_NEUR = enable cycles, N_NEUR+1 = capture.
  localparam int unsigned CW = $clog2(N_NEUR + 2);
  localparam logic [IW-1:0] K_LAST  = IW'(N_NEUR - 1);
  localparam logic [CW-1:0] CE_LAST = CW'(N_NEUR);

  esn_state_e     state_q, state_d;
  logic [IW-1:0]  k_q, k_d;            // neuron currently being updated
  logic           pend_q, pend_d;      // a res_go is outstanding
  logic [CW-1:0]  ro_cnt_q, ro_cnt_d;
  logic [DW-1:0]  sample_q, sample_d;
  logic [DW-1:0]  est_q, est_d;
  logic           est_valid_q, est_valid_d;

`ifdef ESN_WASHOUT_EN
  localparam int unsigned   WCW      = $clog2(WASHOUT + 1);
  localparam logic [WCW-1:0] WASH_MAX = WCW'(WASHOUT);
  logic [WCW-1:0] wash_q, wash_d;      // completed samples, saturating
`else
  logic [31:0] unused_washout;
  assign unused_washout = 32'(WASHOUT);
`endif

  // The latched sample feeds the reservoir datapath, which lives outside this
  // block and has no port here; fold it into a sink so it stays visible.
  logic unused_sample;
  assign unused_sample = ^sample_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its peers' pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      pend_q      <= 1'b0;
      ro_cnt_q    <= '0;
      sample_q    <= '0;
      est_q       <= '0;
      est_valid_q <= 1'b0;
`ifdef ESN_WASHOUT_EN
      wash_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      pend_q      <= pend_d;
      ro_cnt_q    <= ro_cnt_d;
      sample_q    <= sample_d;
      est_q       <= est_d;
      est_valid_q <= est_valid_d;
`ifdef ESN_WASHOUT_EN
      wash_q      <= wash_d;
`endif
    end
  end

  // NOTE: every next-state value and output is defaulted first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    pend_d      = pend_q;
    ro_cnt_d    = ro_cnt_q;
    sample_d    = sample_q;
    est_d       = est_q;
    est_valid_d = est_valid_q;
`ifdef ESN_WASHOUT_EN
    wash_d      = wash_q;
`endif
    in_ready    = 1'b0;
    res_go      = 1'b0;
    ro_clr      = 1'b0;
    ro_ce       = 1'b0;
    ro_idx      = '0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sample_d = in_data;
          k_d      = '0;
          pend_d   = 1'b0;
          state_d  = RES;
        end
      end

      RES: begin
        // res_done only counts once the command has been seen, so a done
        // coincident with res_go (pend_q still low) is ignored.
        if (!pend_q) begin
          res_go = 1'b1;
          pend_d = 1'b1;
        end else if (res_done) begin
          pend_d = 1'b0;
          if (k_q == K_LAST) begin
            k_d      = '0;
            ro_cnt_d = '0;
            state_d  = RO;
          end else begin
            k_d = k_q + IW'(1);
          end
        end
      end

      RO: begin
        ro_cnt_d = ro_cnt_q + CW'(1);
        if (ro_cnt_q == '0) begin
          ro_clr = 1'b1;
        end else if (ro_cnt_q <= CE_LAST) begin
          ro_ce  = 1'b1;
          ro_idx = IW'(ro_cnt_q - CW'(1));
        end else begin
          // acc_in now reflects the last enable cycle.
          ro_cnt_d = '0;
`ifdef ESN_WASHOUT_EN
          if (wash_q != WASH_MAX) begin
            wash_d  = wash_q + WCW'(1);
            state_d = IDLE;
          end else begin
            est_d       = acc_in;
            est_valid_d = 1'b1;
            state_d     = OUT;
          end
`else
          est_d       = acc_in;
          est_valid_d = 1'b1;
          state_d     = OUT;
`endif
        end
      end

      OUT: begin
        if (est_ready) begin
          est_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign res_idx    = k_q;
  assign est        = est_q;
  assign est_valid  = est_valid_q;
  assign busy       = (state_q != IDLE);
  // Weight writes stall while the readout walks the bank.
  assign w_wr_ready = (state_q != RO);

  esn_wout_bank #(
    .N_NEUR (N_NEUR),
    .DW     (DW)
  ) u_wout_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (w_wr_valid && w_wr_ready),
    .wr_idx_i  (w_wr_idx),
    .wr_data_i (w_wr_data),
    .w_out_o   (W_out)
  );

endmodule : esn_sched
